// File: rtl/uart_block_rx.sv
// UART receiver that packs BLOCK_BYTES good bytes into one wide word (first byte in the MSBs)
// behind a ready/valid output register, with parity/stop checking and an inter-byte timeout.
module uart_block_rx #(
   parameter int CLK_DIV      = 5208,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int BLOCK_BYTES  = 16,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx,
   output logic [8*BLOCK_BYTES-1:0] blk_data,
   output logic                     blk_valid,
   input  logic                     blk_ready,
   output logic                     err_frame,
   output logic                     err_parity,
   output logic                     err_timeout,
   output logic                     err_overrun,
   output logic                     busy
);
   localparam int BW = $clog2(CLK_DIV);
   localparam int CW = $clog2(BLOCK_BYTES + 1);
   localparam int TO = TIMEOUT_BITS * CLK_DIV;
   localparam int IW = $clog2(TO + 1);
   localparam int DW = 8 * BLOCK_BYTES;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   state_t          r_state, w_next;
   logic [1:0]      r_sync;
   logic            r_rx_prev;
   logic [BW-1:0]   r_baud;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
   logic            r_par_err, r_frm_err;
   logic [CW-1:0]   r_cnt;
   logic [IW-1:0]   r_idle;
   logic [DW-1:0]   r_data;
   logic            r_valid;
   logic            r_err_frame, r_err_parity, r_err_timeout, r_err_overrun;

   logic            w_rx, w_fall, w_tick, w_half;
   logic            w_baud_clr, w_data_smp, w_par_smp, w_stop_smp, w_last_stop;
   logic            w_par_exp, w_ferr, w_perr, w_commit, w_full, w_to, w_idle_run;
   logic [CW-1:0]   w_cnt_inc;
   logic [DW-1:0]   w_asm_next;

   assign w_rx      = r_sync[1];
   assign w_fall    = r_rx_prev & ~w_rx;
   assign w_tick    = (r_baud == BW'(CLK_DIV - 1));
   assign w_half    = (r_baud == BW'(CLK_DIV / 2 - 1));
   assign w_par_exp = (PARITY == 1) ? ~^r_shift : ^r_shift;
   assign w_ferr    = r_frm_err | ~w_rx;
   assign w_perr    = r_par_err;
   assign w_commit  = w_last_stop & ~w_ferr & ~w_perr;
   assign w_cnt_inc = r_cnt + CW'(1);
   assign w_full    = (w_cnt_inc == CW'(BLOCK_BYTES));
   assign w_idle_run = (r_state == S_IDLE) && (r_cnt != '0);
   assign w_to      = w_idle_run && (r_idle == IW'(TO - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_fall) w_next = S_START;
         S_START: if (w_half) w_next = w_rx ? S_IDLE : S_DATA;
         S_DATA:  if (w_tick && r_bit == 3'd7) w_next = (PARITY != 0) ? S_PAR : S_STOP;
         S_PAR:   if (w_tick) w_next = S_STOP;
         S_STOP:  if (w_tick && r_bit == 3'(STOP_BITS - 1)) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_baud_clr  = (r_state == S_IDLE) || ((r_state == S_START) ? w_half : w_tick);
      w_data_smp  = (r_state == S_DATA) && w_tick;
      w_par_smp   = (r_state == S_PAR)  && w_tick;
      w_stop_smp  = (r_state == S_STOP) && w_tick;
      w_last_stop = w_stop_smp && (r_bit == 3'(STOP_BITS - 1));
      busy        = (r_state != S_IDLE) || (r_cnt != '0);
   end

   // Assembly holds only the BLOCK_BYTES-1 older bytes; the newest byte comes straight from r_shift.
   generate
      if (BLOCK_BYTES > 1) begin : g_asm
         logic [DW-9:0] r_asm;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)                     r_asm <= '0;
            else if (w_commit && !w_full) r_asm <= w_asm_next[DW-9:0];
         end
         assign w_asm_next = {r_asm, r_shift};
      end else begin : g_asm1
         assign w_asm_next = r_shift;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync        <= 2'b11;
         r_rx_prev     <= 1'b1;
         r_baud        <= '0;
         r_bit         <= '0;
         r_shift       <= '0;
         r_par_err     <= 1'b0;
         r_frm_err     <= 1'b0;
         r_cnt         <= '0;
         r_idle        <= '0;
         r_data        <= '0;
         r_valid       <= 1'b0;
         r_err_frame   <= 1'b0;
         r_err_parity  <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_overrun <= 1'b0;
      end else begin
         r_err_frame   <= 1'b0;
         r_err_parity  <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_overrun <= 1'b0;
         r_sync        <= {r_sync[0], rx};
         r_rx_prev     <= w_rx;
         r_baud        <= w_baud_clr ? '0 : r_baud + BW'(1);
         if (r_state != w_next) r_bit <= '0;
         else if (w_tick)       r_bit <= r_bit + 3'd1;

         if (r_state == S_START) begin
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
         end
         if (w_data_smp)            r_shift   <= {w_rx, r_shift[7:1]};
         if (w_par_smp)             r_par_err <= (w_rx != w_par_exp);
         if (w_stop_smp && !w_rx)   r_frm_err <= 1'b1;

         r_idle <= (w_idle_run && !w_to) ? r_idle + IW'(1) : '0;

         if (r_valid && blk_ready) r_valid <= 1'b0;

         if (w_last_stop) begin
            if (w_ferr || w_perr) begin
               r_cnt        <= '0;
               r_err_frame  <= w_ferr;
               r_err_parity <= w_perr;
            end else if (w_full) begin
               r_cnt <= '0;
               if (!r_valid || blk_ready) begin
                  r_data  <= w_asm_next;
                  r_valid <= 1'b1;
               end else begin
                  r_err_overrun <= 1'b1;
               end
            end else begin
               r_cnt <= w_cnt_inc;
            end
         end else if (w_to) begin
            r_cnt         <= '0;
            r_err_timeout <= 1'b1;
         end
      end
   end

   assign blk_data    = r_data;
   assign blk_valid   = r_valid;
   assign err_frame   = r_err_frame;
   assign err_parity  = r_err_parity;
   assign err_timeout = r_err_timeout;
   assign err_overrun = r_err_overrun;
endmodule

// File: tb/tb_uart_block_rx.sv
// Directed-sequence bench with random payloads for uart_block_rx: one 8N1 and one 8E1 receiver,
// each compared against a byte-queue reference model.
module tb_uart_block_rx;
  localparam int CD = 16;
  localparam int NB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rdy0 = 1'b0, rdy1 = 1'b0;
  logic [127:0] d0, d1;
  logic v0, fe0, pe0, to0, ov0, bz0;
  logic v1, fe1, pe1, to1, ov1, bz1;

  int checks = 0, failures = 0;
  int n_fe[2], n_pe[2], n_to[2], n_ov[2];
  int b_fe, b_pe, b_to, b_ov;

  logic [7:0]   q0[$], q1[$];
  logic [127:0] md[2];
  bit           mv[2];
  int           eov[2];

  always #5 clk = ~clk;

  uart_block_rx #(.CLK_DIV(CD), .PARITY(0), .STOP_BITS(1), .BLOCK_BYTES(NB), .TIMEOUT_BITS(20)) u0 (
    .clk(clk), .rst(rst), .rx(rx0), .blk_data(d0), .blk_valid(v0), .blk_ready(rdy0),
    .err_frame(fe0), .err_parity(pe0), .err_timeout(to0), .err_overrun(ov0), .busy(bz0));

  uart_block_rx #(.CLK_DIV(CD), .PARITY(2), .STOP_BITS(1), .BLOCK_BYTES(NB), .TIMEOUT_BITS(20)) u1 (
    .clk(clk), .rst(rst), .rx(rx1), .blk_data(d1), .blk_valid(v1), .blk_ready(rdy1),
    .err_frame(fe1), .err_parity(pe1), .err_timeout(to1), .err_overrun(ov1), .busy(bz1));

  initial begin
    for (int i = 0; i < 2; i++) begin n_fe[i] = 0; n_pe[i] = 0; n_to[i] = 0; n_ov[i] = 0; end
  end

  always @(negedge clk) begin
    if (fe0) n_fe[0]++;
    if (pe0) n_pe[0]++;
    if (to0) n_to[0]++;
    if (ov0) n_ov[0]++;
    if (fe1) n_fe[1]++;
    if (pe1) n_pe[1]++;
    if (to1) n_to[1]++;
    if (ov1) n_ov[1]++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap(input int d);
    b_fe = n_fe[d]; b_pe = n_pe[d]; b_to = n_to[d]; b_ov = n_ov[d];
  endtask

  function automatic logic [127:0] pack(input logic [7:0] q[$]);
    logic [127:0] r = '0;
    foreach (q[i]) r = {r[119:0], q[i]};
    return r;
  endfunction

  task automatic drive(input int d, input logic v);
    if (d == 0) rx0 = v; else rx1 = v;
  endtask

  task automatic bit_time(input int d, input logic v);
    #1 drive(d, v);
    repeat (CD) @(posedge clk);
  endtask

  // Serial frame: start, 8 data LSB first, even parity on the 8E1 line (optionally inverted), stop.
  task automatic send(input int d, input logic [7:0] b, input bit bad_par, input logic stopv);
    bit_time(d, 1'b0);
    for (int i = 0; i < 8; i++) bit_time(d, b[i]);
    if (d == 1) bit_time(d, (^b) ^ bad_par);
    bit_time(d, stopv);
    if (!stopv) bit_time(d, 1'b1);
  endtask

  task automatic complete(input int d, input logic [127:0] blk);
    logic r;
    r = (d == 0) ? rdy0 : rdy1;
    if (!mv[d] || r) begin md[d] = blk; mv[d] = 1'b1; end
    else eov[d]++;
  endtask

  task automatic good(input int d, input logic [7:0] b);
    send(d, b, 1'b0, 1'b1);
    if (d == 0) begin
      q0.push_back(b);
      if (q0.size() == NB) begin complete(0, pack(q0)); q0.delete(); end
    end else begin
      q1.push_back(b);
      if (q1.size() == NB) begin complete(1, pack(q1)); q1.delete(); end
    end
  endtask

  logic [7:0] t1 [16];

  initial begin
    t1 = '{8'h68, 8'h1E, 8'hDF, 8'h34, 8'hD2, 8'h06, 8'h96, 8'h5E,
           8'h86, 8'hB3, 8'hE9, 8'h4F, 8'h53, 8'h6E, 8'h42, 8'h46};
    mv = '{1'b0, 1'b0}; md = '{128'h0, 128'h0}; eov = '{0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 128'(v0), 128'(0));
    chk("rst_data", d0, 128'h0);
    chk("rst_busy", 128'(bz0), 128'(0));
    chk("rst_errs", 128'({fe0, pe0, to0, ov0}), 128'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: reference 16-byte block, 8N1
    snap(0);
    foreach (t1[i]) good(0, t1[i]);
    @(negedge clk);
    chk("t1_valid", 128'(v0), 128'(mv[0]));
    chk("t1_data", d0, 128'h681EDF34D206965E86B3E94F536E4246);
    chk("t1_errs", 128'((n_fe[0]-b_fe) + (n_pe[0]-b_pe) + (n_to[0]-b_to) + (n_ov[0]-b_ov)), 128'(0));
    chk("t1_busy", 128'(bz0), 128'(0));
    rdy0 = 1'b1; @(negedge clk); rdy0 = 1'b0; mv[0] = 1'b0;
    chk("t1_handshake", 128'(v0), 128'(0));

    // 3: partial block discarded by timeout
    snap(0);
    for (int i = 0; i < 5; i++) good(0, 8'($urandom));
    @(negedge clk);
    chk("t3_busy_partial", 128'(bz0), 128'(1));
    repeat (18 * CD) @(negedge clk);
    chk("t3_no_early_to", 128'(n_to[0] - b_to), 128'(0));
    repeat (4 * CD) @(negedge clk);
    q0.delete();
    chk("t3_timeout", 128'(n_to[0] - b_to), 128'(1));
    chk("t3_busy_after", 128'(bz0), 128'(0));
    chk("t3_no_valid", 128'(v0), 128'(0));

    // 4: 32 bytes with blk_ready low -> second block overruns
    snap(0);
    for (int i = 0; i < 2 * NB; i++) good(0, 8'($urandom));
    @(negedge clk);
    chk("t4_valid", 128'(v0), 128'(1));
    chk("t4_data_first", d0, md[0]);
    chk("t4_overrun", 128'(n_ov[0] - b_ov), 128'(eov[0]));
    rdy0 = 1'b1; @(negedge clk); rdy0 = 1'b0; mv[0] = 1'b0;
    chk("t4_valid_fall", 128'(v0), 128'(0));

    // 5: frame error on byte 7, glitch false start, then a clean block
    snap(0);
    for (int i = 0; i < 7; i++) good(0, 8'($urandom));
    send(0, 8'($urandom), 1'b0, 1'b0);
    q0.delete();
    @(negedge clk);
    chk("t5_frame", 128'(n_fe[0] - b_fe), 128'(1));
    chk("t5_busy_cleared", 128'(bz0), 128'(0));
    snap(0);
    rx0 = 1'b0; repeat (4) @(negedge clk); rx0 = 1'b1;
    repeat (3 * CD) @(negedge clk);
    chk("t5_glitch_errs", 128'((n_fe[0]-b_fe) + (n_pe[0]-b_pe)), 128'(0));
    chk("t5_glitch_busy", 128'(bz0), 128'(0));
    for (int i = 0; i < NB; i++) good(0, 8'($urandom));
    @(negedge clk);
    chk("t5_valid", 128'(v0), 128'(mv[0]));
    chk("t5_data", d0, md[0]);

    // Reset mid-byte with a block still held
    bit_time(0, 1'b0);
    for (int i = 0; i < 3; i++) bit_time(0, 1'b1);
    @(negedge clk); rst = 1'b1; rx0 = 1'b1;
    @(negedge clk);
    chk("mrst_valid", 128'(v0), 128'(0));
    chk("mrst_data", d0, 128'h0);
    chk("mrst_busy", 128'(bz0), 128'(0));
    rst = 1'b0; q0.delete(); q1.delete(); mv = '{1'b0, 1'b0};
    repeat (4) @(negedge clk);

    // 2: even parity, bad parity on 0x68 after 3 good bytes
    snap(1);
    for (int i = 0; i < 3; i++) good(1, 8'($urandom));
    send(1, 8'h68, 1'b1, 1'b1);
    q1.delete();
    @(negedge clk);
    chk("t2_parity", 128'(n_pe[1] - b_pe), 128'(1));
    chk("t2_no_frame", 128'(n_fe[1] - b_fe), 128'(0));
    chk("t2_busy", 128'(bz1), 128'(0));
    for (int i = 0; i < NB; i++) good(1, 8'($urandom));
    @(negedge clk);
    chk("t2_valid", 128'(v1), 128'(mv[1]));
    chk("t2_data", d1, md[1]);
    chk("t2_parity_once", 128'(n_pe[1] - b_pe), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_block_rx.md
# uart_block_rx

Parametrised UART receiver with block assembly. It deserialises asynchronous serial frames on `rx` and packs BLOCK_BYTES consecutive bytes into one wide word for the SM4 datapath. The first byte received lands in the MSBs. Compared with the fixed 8N1/16-byte receive path, it adds:
- selectable parity and stop-bit count;
- an inter-byte timeout that discards partial blocks;
- a ready/valid output register with overrun detection.

## Interface

Parameters:
- CLK_DIV, 5208: clock cycles per bit (50 MHz / 9600 baud); minimum 8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- BLOCK_BYTES, 16: bytes per output block; minimum 1.
- TIMEOUT_BITS, 20: idle bit-times allowed between bytes of a partial block.

Ports (clock and reset first):
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial input, idle high; asynchronous to clk.
- blk_data  out  8*BLOCK_BYTES  assembled block; byte 0 is in [8*BLOCK_BYTES-1 -: 8].
- blk_valid  out  1  blk_data holds an unconsumed block.
- blk_ready  in  1  consumer accepts; handshake completes when blk_valid && blk_ready.
- err_frame  out  1  one-cycle pulse: a stop bit was sampled low.
- err_parity  out  1  one-cycle pulse: the parity bit mismatched.
- err_timeout  out  1  one-cycle pulse: a partial block was discarded by timeout.
- err_overrun  out  1  one-cycle pulse: a completed block was dropped because the output register was full.
- busy  out  1  high while a frame is in progress or a partial block is held.

## Operation

- `rx` passes through a 2-FF synchroniser; the synchroniser resets to 1.
- A start is the synchronised `rx` falling from 1 to 0.
- FSM states and transitions:
  - IDLE -> START on a falling edge.
  - START: at CLK_DIV/2 cycles, sample `rx`. If 1, this is a false start: go to IDLE with no error. If 0, go to DATA.
  - DATA: 8 bits, LSB first, each sampled CLK_DIV cycles after the previous sample. Then go to PARITY if PARITY != 0, else STOP.
  - PARITY: one sample, checked against the selected parity.
  - STOP: STOP_BITS samples; every stop sample must be 1. Then go to IDLE.
- Byte commit happens at the final stop sample when there is no error. The byte is shifted into the assembly register (left shift by 8, new byte in the LSBs) and the byte counter increments.
- Error handling at the final stop sample:
  - A parity or frame error discards the byte, clears the byte counter (aborting the partial block), and pulses the matching error output.
  - If both errors occur, both outputs pulse.
  - A frame error returns to IDLE. A new start is recognised only after `rx` has been seen high.
- When the counter reaches BLOCK_BYTES:
  - If blk_valid is 0, or blk_ready is 1 in that cycle, the assembly register copies to blk_data, blk_valid is set, and the counter clears.
  - Otherwise the block is dropped, err_overrun pulses, and the counter clears. blk_data is unchanged.
- blk_valid clears on a handshake, unless a new block loads in the same cycle, in which case it stays 1.
- Timeout: while the counter is nonzero and the FSM is in IDLE, an idle counter runs. At TIMEOUT_BITS*CLK_DIV cycles, the counter clears and err_timeout pulses. The idle counter restarts on every start detection.
- Reception continues while blk_valid is high; the assembly register is independent of the output register.

## Timing

- Reset values:
  - blk_data = 0; blk_valid = 0; all err_* = 0; busy = 0.
  - FSM = IDLE; byte counter and idle counter = 0; synchroniser = 1.
- Reset mid-frame or mid-block discards everything immediately and raises no error.
- Latency from the `rx` pin edge to start detection is 2–3 cycles (synchroniser).
- blk_valid rises on the clock edge following the final stop-bit sample of the last byte. Error pulses are timed on that same edge.
- blk_data is stable while blk_valid is 1.
- Simultaneous handshake and completion (blk_valid=1, blk_ready=1, block completes): the new block loads and blk_valid stays 1. No overrun.
- With BLOCK_BYTES=1, every good byte produces a block.
- Counter widths: $clog2(CLK_DIV), $clog2(BLOCK_BYTES+1), $clog2(TIMEOUT_BITS*CLK_DIV+1).

## Test plan

Use CLK_DIV=16 in the bench.

1. Send 16 bytes 8N1: 68 1E DF 34 D2 06 96 5E 86 B3 E9 4F 53 6E 42 46 -> one blk_valid with blk_data = 128'h681EDF34D206965E86B3E94F536E4246; no error pulses.
2. PARITY=2: send byte 0x68 with parity bit 0 (wrong; the correct even-parity bit is 1) after 3 good bytes -> err_parity pulses and the counter clears. Then send 16 good bytes -> the block contains only the later 16 bytes.
3. Send 5 bytes, then idle for 20 bit-times -> err_timeout pulses once, busy falls, and no blk_valid.
4. Hold blk_ready=0 and send 32 bytes -> the first block is valid, the second completion pulses err_overrun, and blk_data still holds the first block. Then raise blk_ready -> blk_valid falls.
5. Send a stop bit of 0 on byte 7 -> err_frame pulses. Glitch `rx` low for 4 cycles -> false start with no error and no byte. Assert rst mid-byte -> all outputs return to reset values.
